// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one valid/ready bus access per load/store, stalling upstream until done.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_THREADS   = 8,
  localparam int unsigned BITS_THREADS = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_write_m,
  input  logic [1:0]               result_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [ADDRESS_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0]    write_data_m,
  input  logic [BITS_THREADS-1:0]  tid_m,
  output logic                     stall_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic                     load_valid_m,
  output logic [BITS_THREADS-1:0]  tid_done_m,
  output logic                     misalign_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [3:0]               dmem_be,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  input  logic                     dmem_ready,
  input  logic                     dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [1:0]                lane_q;
  logic [2:0]                f3_q;
  logic                      we_q;
  logic [BITS_THREADS-1:0]   tid_q;
  logic [3:0]                be_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [BITS_THREADS-1:0]   tid_done_q;
  logic                      misalign_q;

  logic                      access;
  logic                      misaligned;
  logic                      capture;
  logic                      rd_cap;
  logic [3:0]                be_calc;
  logic [DATA_WIDTH-1:0]     wdata_calc;
  logic [DATA_WIDTH-1:0]     rd_ext;
  logic [7:0]                lb;
  logic [15:0]               lh;

  assign access = mem_write_m | (result_src_m == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = access & (((funct3_m[1:0] == 2'b01) & alu_result_m[0]) |
                                (funct3_m[1] & (alu_result_m[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = write_data_m;
    unique case (funct3_m[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << alu_result_m[1:0];
        wdata_calc = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {alu_result_m[1], 1'b0};
        wdata_calc = {2{write_data_m[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the captured low address bits; half ignores bit 0.
  always_comb begin
    lb = 8'h00;
    unique case (lane_q)
      2'd0: lb = dmem_rdata[7:0];
      2'd1: lb = dmem_rdata[15:8];
      2'd2: lb = dmem_rdata[23:16];
      2'd3: lb = dmem_rdata[31:24];
      default: ;
    endcase
    lh = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (f3_q)
      3'b000:  rd_ext = {{(DATA_WIDTH-8){lb[7]}}, lb};
      3'b001:  rd_ext = {{(DATA_WIDTH-16){lh[15]}}, lh};
      3'b100:  rd_ext = {{(DATA_WIDTH-8){1'b0}}, lb};
      3'b101:  rd_ext = {{(DATA_WIDTH-16){1'b0}}, lh};
      default: rd_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    rd_cap  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access && !misaligned) begin
          capture = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (dmem_ready) begin
          if (we_q) begin
            state_d = StDone;
          end else if (dmem_rvalid) begin
            rd_cap  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          rd_cap  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      lane_q     <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      tid_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      tid_done_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= (state_q == StIdle) & misaligned;
      if (capture) begin
        addr_q  <= {alu_result_m[ADDRESS_WIDTH-1:2], 2'b00};
        lane_q  <= alu_result_m[1:0];
        f3_q    <= funct3_m;
        we_q    <= mem_write_m;
        tid_q   <= tid_m;
        be_q    <= be_calc;
        wdata_q <= wdata_calc;
      end
      if (rd_cap) rdata_q <= rd_ext;
      if ((state_d == StDone) && (state_q != StDone)) begin
        tid_done_q <= tid_q;
      end else if ((state_q == StIdle) && misaligned) begin
        tid_done_q <= tid_m;
      end
    end
  end

  assign stall_m      = (state_q != StDone) & ((access & ~misaligned) | (state_q != StIdle));
  assign dmem_req     = (state_q == StReq);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign read_data_m  = rdata_q;
  assign load_valid_m = (state_q == StDone) & ~we_q;
  assign tid_done_m   = tid_done_q;
  assign misalign_m   = misalign_q;

endmodule
